instr_mem_loader: RTL and testbench

- Writer side of the byte-addressed, big-endian instruction ROM that the processor reads by program counter.
- Accepts 32-bit instruction words over a valid/ready stream and writes each one as 4 sequential byte writes, MSB first, into the memory's byte write port.
- Holds the processor (cpu_hold) until the last word is committed.

---
 rtl/instr_mem_loader_if.sv | 22 ++
 rtl/instr_mem_loader.sv | 170 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - word stream in and byte write port out of the instruction loader
interface instr_mem_loader_if;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_last;
    logic        word_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    // Host side: supplies program words and observes the memory writes.
    modport master (
        output word_in, word_valid, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side: consumes program words and drives the memory byte port.
    modport slave (
        input  word_in, word_valid, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads 32-bit words into a big-endian byte-addressed instruction ROM
module instr_mem_loader #(
    parameter int MEM_BYTES = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    instr_mem_loader_if.slave    bus,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 overflow,
    output logic [CNT_W-1:0]     words_loaded
);

    typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} state_t;

    // Highest pointer at which a whole word still fits.
    localparam logic [31:0] LAST_SLOT = 32'(MEM_BYTES - 4);

    state_t            state, state_nxt;
    logic [31:0]       ptr, ptr_nxt;
    logic [1:0]        idx, idx_nxt, idx_inc;
    logic [31:0]       word_q, word_nxt;
    logic              last_q, last_nxt;
    logic              ready_q, ready_nxt;
    logic              we_q, we_nxt;
    logic [31:0]       addr_q, addr_nxt;
    logic [7:0]        wdata_q, wdata_nxt;
    logic              hold_q, hold_nxt;
    logic              done_q, done_nxt;
    logic              ovf_q, ovf_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;

    assign idx_inc = idx + 2'd1;

    // Byte k of a word, MSB first, so byte 0 lands at the lowest address.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    // Next-state and next-output decode; every output is computed one cycle ahead and registered.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        word_nxt  = word_q;
        last_nxt  = last_q;
        ready_nxt = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        hold_nxt  = hold_q;
        done_nxt  = done_q;
        ovf_nxt   = ovf_q;
        cnt_nxt   = cnt_q;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCEPT;
                    ready_nxt = 1'b1;
                    ptr_nxt   = '0;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b0;
                    ovf_nxt   = 1'b0;
                end
            end
            ACCEPT: begin
                if (bus.word_valid && ready_q) begin
                    if (ptr <= LAST_SLOT) begin
                        state_nxt = WRITE;
                        word_nxt  = bus.word_in;
                        last_nxt  = bus.word_last;
                        idx_nxt   = 2'd0;
                        we_nxt    = 1'b1;
                        addr_nxt  = ptr;
                        wdata_nxt = bus.word_in[31:24];
                    end else begin
                        state_nxt = ERROR;
                        ovf_nxt   = 1'b1;
                    end
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            WRITE: begin
                if (idx != 2'd3) begin
                    idx_nxt   = idx_inc;
                    we_nxt    = 1'b1;
                    addr_nxt  = ptr + 32'(idx_inc);
                    wdata_nxt = byte_of(word_q, idx_inc);
                end else begin
                    ptr_nxt = ptr + 32'd4;
                    cnt_nxt = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    if (last_q) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        hold_nxt  = 1'b0;
                    end else begin
                        state_nxt = ACCEPT;
                        ready_nxt = 1'b1;
                    end
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    state_nxt = ACCEPT;
                    ready_nxt = 1'b1;
                    ptr_nxt   = '0;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b0;
                    ovf_nxt   = 1'b0;
                    hold_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight word immediately.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= IDLE;
            ptr     <= '0;
            idx     <= 2'd0;
            word_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            idx     <= idx_nxt;
            word_q  <= word_nxt;
            last_q  <= last_nxt;
            ready_q <= ready_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            hold_q  <= hold_nxt;
            done_q  <= done_nxt;
            ovf_q   <= ovf_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign bus.word_ready = ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign cpu_hold       = hold_q;
    assign done           = done_q;
    assign overflow       = ovf_q;
    assign words_loaded   = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst, start, sel;
    logic [31:0] word_in;
    logic        word_valid, word_last;

    instr_mem_loader_if bus64();
    instr_mem_loader_if bus8();

    assign bus64.word_in    = word_in;
    assign bus64.word_valid = word_valid;
    assign bus64.word_last  = word_last;
    assign bus8.word_in     = word_in;
    assign bus8.word_valid  = word_valid;
    assign bus8.word_last   = word_last;

    logic        hold64, done64, ovf64, hold8, done8, ovf8;
    logic [15:0] wl64, wl8;

    instr_mem_loader #(.MEM_BYTES(64), .CNT_W(16)) dut64 (
        .Clk(Clk), .Rst(Rst), .start(start), .bus(bus64),
        .cpu_hold(hold64), .done(done64), .overflow(ovf64), .words_loaded(wl64)
    );

    instr_mem_loader #(.MEM_BYTES(8), .CNT_W(16)) dut8 (
        .Clk(Clk), .Rst(Rst), .start(start), .bus(bus8),
        .cpu_hold(hold8), .done(done8), .overflow(ovf8), .words_loaded(wl8)
    );

    // Observed view: sel picks the 8-byte instance, otherwise the 64-byte one.
    logic        rdy, we, hold, dn, ovf;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [15:0] wl;
    assign rdy   = sel ? bus8.word_ready : bus64.word_ready;
    assign we    = sel ? bus8.mem_we     : bus64.mem_we;
    assign addr  = sel ? bus8.mem_addr   : bus64.mem_addr;
    assign wdata = sel ? bus8.mem_wdata  : bus64.mem_wdata;
    assign hold  = sel ? hold8  : hold64;
    assign dn    = sel ? done8  : done64;
    assign ovf   = sel ? ovf8   : ovf64;
    assign wl    = sel ? wl8    : wl64;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [31:0] log_addr[$];
    logic [7:0]  log_data[$];
    int          log_cyc[$];
    int          overlap_cnt = 0;

    always @(negedge Clk) begin
        if (we === 1'b1) begin
            log_addr.push_back(addr);
            log_data.push_back(wdata);
            log_cyc.push_back(cyc);
            if (rdy !== 1'b0) overlap_cnt <= overlap_cnt + 1;
        end
    end

    logic [31:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int          exp_ptr, exp_words;
    bit          exp_done, exp_ovf;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic model_start;
        exp_ptr   = 0;
        exp_words = 0;
        exp_done  = 0;
        exp_ovf   = 0;
    endtask

    task automatic model_word(input logic [31:0] w, input bit last);
        int mb = sel ? 8 : 64;
        if (exp_ptr + 4 <= mb) begin
            for (int k = 0; k < 4; k++) begin
                exp_addr.push_back(32'(exp_ptr + k));
                exp_data.push_back(8'(w >> (8 * (3 - k))));
            end
            exp_ptr += 4;
            exp_words++;
            if (last) exp_done = 1;
        end else begin
            exp_ovf = 1;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
        model_start;
    endtask

    task automatic do_reset;
        Rst = 1'b0;
        start = 1'b0;
        word_valid = 1'b0;
        word_last = 1'b0;
        tick;
        tick;
        Rst = 1'b1;
        model_start;
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic send_word(input logic [31:0] w, input bit last, output int hs);
        bit got = 0;
        hs = -1;
        word_in = w;
        word_valid = 1'b1;
        word_last = last;
        for (int i = 0; i < 50 && !got; i++) begin
            if (rdy === 1'b1) begin
                hs = cyc;
                got = 1;
            end
            tick;
        end
        word_valid = 1'b0;
        word_last = 1'b0;
        check("handshake", 64'(got), 64'd1);
        if (got) model_word(w, last);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_words"},    64'(wl),   64'(exp_words));
        check({tag, "_done"},     64'(dn),   64'(exp_done));
        check({tag, "_overflow"}, 64'(ovf),  64'(exp_ovf));
        check({tag, "_hold"},     64'(hold), 64'(!exp_done));
    endtask

    task automatic check_log(input string tag);
        int n = exp_addr.size();
        check({tag, "_wcount"}, 64'(log_addr.size()), 64'(n));
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            check({tag, "_addr"}, 64'(log_addr[i]), 64'(exp_addr[i]));
            check({tag, "_data"}, 64'(log_data[i]), 64'(exp_data[i]));
        end
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    initial begin
        int h, h1, h2, h3, n;
        Rst = 1'b0; start = 1'b0; sel = 1'b0;
        word_in = '0; word_valid = 1'b0; word_last = 1'b0;
        model_start;

        // Reset values
        tick; tick;
        check("rst_hold",  64'(hold),  64'd1);
        check("rst_ready", 64'(rdy),   64'd0);
        check("rst_we",    64'(we),    64'd0);
        check("rst_addr",  64'(addr),  64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_done",  64'(dn),    64'd0);
        check("rst_ovf",   64'(ovf),   64'd0);
        check("rst_words", 64'(wl),    64'd0);
        Rst = 1'b1;
        tick; tick; tick;
        check("idle_ready",  64'(rdy), 64'd0);
        check("idle_nowr",   64'(log_addr.size()), 64'd0);
        check("idle_hold",   64'(hold), 64'd1);

        // Single word
        pulse_start;
        send_word(32'h8C220004, 1'b1, h);
        tick; tick; tick;
        check("single_hold_last_byte", 64'(hold), 64'd1);
        tick;
        check("single_first_we", 64'(log_cyc[0]), 64'(h + 1));
        check("single_last_we",  64'(log_cyc[3]), 64'(h + 4));
        check_state("single");
        check_log("single");

        // Back-to-back words
        pulse_start;
        send_word(32'h11223344, 1'b0, h1);
        send_word(32'h55667788, 1'b0, h2);
        send_word(32'h99AABBCC, 1'b1, h3);
        tick; tick; tick; tick;
        check("b2b_gap12", 64'(h2 - h1), 64'd5);
        check("b2b_gap23", 64'(h3 - h2), 64'd5);
        check("b2b_span",  64'(log_cyc[11] - h1), 64'd14);
        check("b2b_ready_in_write", 64'(overlap_cnt), 64'd0);
        check_state("b2b");
        check_log("b2b");

        // Overflow on the 8-byte instance
        sel = 1'b1;
        do_reset;
        pulse_start;
        send_word($urandom, 1'b0, h);
        send_word($urandom, 1'b0, h);
        send_word($urandom, 1'b1, h);
        tick; tick; tick; tick; tick; tick;
        check("ovf_ready", 64'(rdy), 64'd0);
        check_state("ovf");
        check_log("ovf");
        pulse_start;
        check("ovf_clear", 64'(ovf), 64'd0);
        check("ovf_restart_hold", 64'(hold), 64'd1);
        send_word($urandom, 1'b1, h);
        tick; tick; tick; tick;
        check_state("ovf_restart");
        check_log("ovf_restart");

        // Reset during byte index 2 of word 2
        sel = 1'b0;
        do_reset;
        pulse_start;
        send_word($urandom, 1'b0, h);
        send_word($urandom, 1'b0, h);
        tick; tick;
        Rst = 1'b0;
        tick;
        Rst = 1'b1;
        check("midrst_we",    64'(we),   64'd0);
        check("midrst_words", 64'(wl),   64'd0);
        check("midrst_hold",  64'(hold), 64'd1);
        check("midrst_ready", 64'(rdy),  64'd0);
        void'(exp_addr.pop_back());
        void'(exp_data.pop_back());
        check_log("midrst");
        tick;
        pulse_start;
        send_word($urandom, 1'b1, h);
        tick; tick; tick; tick;
        check_state("midrst_after");
        check_log("midrst_after");

        // Ignored inputs, and reload from DONE
        pulse_start;
        check("reload_hold",  64'(hold), 64'd1);
        check("reload_words", 64'(wl),   64'd0);
        check("reload_done",  64'(dn),   64'd0);
        send_word(32'hCAFE0001, 1'b0, h);
        start = 1'b1; word_valid = 1'b1; word_in = 32'hDEADBEEF; word_last = 1'b1;
        tick; tick;
        start = 1'b0; word_valid = 1'b0; word_last = 1'b0;
        tick; tick;
        check("ign_ready_after_write", 64'(rdy), 64'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        check("ign_start_words", 64'(wl),  64'd1);
        check("ign_start_ready", 64'(rdy), 64'd1);
        check("ign_wcount", 64'(log_addr.size()), 64'd4);
        send_word(32'hF00D0002, 1'b1, h);
        tick; tick; tick; tick;
        check_state("ign");
        check_log("ign");

        // Randomized sessions on either instance
        for (int s = 0; s < 8; s++) begin
            sel = 1'($urandom_range(0, 1));
            do_reset;
            pulse_start;
            n = sel ? $urandom_range(1, 3) : $urandom_range(1, 17);
            for (int i = 0; i < n && !exp_ovf; i++) begin
                repeat ($urandom_range(0, 3)) tick;
                send_word($urandom, i == n - 1, h);
            end
            repeat (8) tick;
            check_state("rand");
            check_log("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
